// File: rtl/hazard_pkg.sv
// -----------------------------------------------------------------------------
// hazard_pkg
// Shared types and helpers for the pipeline hazard controller:
//   - operand forwarding select encodings
//   - memory sequencing FSM state encodings
//   - scoreboard entry record for in-flight instructions
//   - pick_sel: forwarding select decision for one source operand
// -----------------------------------------------------------------------------
package hazard_pkg;

    localparam logic [1:0] FORW_SEL_NONE     = 2'b00;
    localparam logic [1:0] FORW_SEL_FROM_MEM = 2'b01;
    localparam logic [1:0] FORW_SEL_FROM_WB  = 2'b10;

    typedef enum logic [1:0] {
        ST_RUN      = 2'b00,
        ST_MEM_WAIT = 2'b01,
        ST_ERR      = 2'b10
    } hz_state_t;

    typedef struct packed {
        logic       valid;
        logic       wb_en;
        logic       mem_read;
        logic       mem_write;
        logic [3:0] dst;
    } sb_entry_t;

    localparam sb_entry_t SB_BUBBLE = '0;

    function automatic logic is_mem_op(input sb_entry_t e);
        return e.valid && (e.mem_read || e.mem_write);
    endfunction

    // The producer in EX will sit in MEM when the consumer reaches EX, so an
    // EX hit forwards from MEM; a MEM hit forwards from WB. The nearer
    // producer is the newer value and wins.
    function automatic logic [1:0] pick_sel(input logic fwd, input logic ex_hit,
                                            input logic mem_hit);
        if (!fwd)
            return FORW_SEL_NONE;
        else if (ex_hit)
            return FORW_SEL_FROM_MEM;
        else if (mem_hit)
            return FORW_SEL_FROM_WB;
        else
            return FORW_SEL_NONE;
    endfunction

endpackage

// File: rtl/sb_match.sv
// -----------------------------------------------------------------------------
// sb_match
// Combinational comparator: does a scoreboard entry write the register that a
// source operand reads?
//   valid, wb_en  in  entry attributes
//   dst           in  entry destination register
//   src           in  source register number being read
//   match         out entry is live, writes back, and targets src
// -----------------------------------------------------------------------------
module sb_match (
    input  logic       valid,
    input  logic       wb_en,
    input  logic [3:0] dst,
    input  logic [3:0] src,
    output logic       match
);

    assign match = valid & wb_en & (dst == src);

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// pipeline_hazard_ctrl
// Central hazard / sequencing controller for the 5-stage pipeline. Tracks the
// destinations in flight in EX and MEM, decides stall / flush / freeze each
// cycle, registers the EX operand forwarding selects, and watches for a memory
// access that never completes.
//   clk, rst                 clock, asynchronous active-high reset
//   fwd_en                   1 = forwarding, 0 = stall-only resolution
//   id_*                     instruction currently in ID
//   branch_taken             EX resolved a taken branch
//   mem_ready                data memory completes the MEM access this cycle
//   stall, flush, freeze     pipeline register enable / clear controls
//   sel_src1, sel_src2       EX operand forwarding selects
//   err                      sticky memory-timeout flag
// -----------------------------------------------------------------------------
module pipeline_hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       fwd_en,
    input  logic       id_valid,
    input  logic [3:0] id_src1,
    input  logic [3:0] id_src2,
    input  logic       id_use_src2,
    input  logic       id_wb_en,
    input  logic       id_mem_read,
    input  logic       id_mem_write,
    input  logic [3:0] id_dst,
    input  logic       branch_taken,
    input  logic       mem_ready,
    output logic       stall,
    output logic       flush,
    output logic       freeze,
    output logic [1:0] sel_src1,
    output logic [1:0] sel_src2,
    output logic       err
);

    // The WB stage needs no entry of its own: the register file writes before
    // it reads, so an instruction leaving MEM can no longer cause a hazard.
    sb_entry_t        ex_q, mem_q, id_entry;
    hz_state_t        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic ex_hit1, ex_hit2, mem_hit1, mem_hit2;
    logic ex_any, mem_any, hazard, mem_busy, freeze_int, bubble;
    logic [1:0] sel1_d, sel2_d;

    sb_match u_ex_src1  (.valid(ex_q.valid),  .wb_en(ex_q.wb_en),  .dst(ex_q.dst),  .src(id_src1), .match(ex_hit1));
    sb_match u_ex_src2  (.valid(ex_q.valid),  .wb_en(ex_q.wb_en),  .dst(ex_q.dst),  .src(id_src2), .match(ex_hit2));
    sb_match u_mem_src1 (.valid(mem_q.valid), .wb_en(mem_q.wb_en), .dst(mem_q.dst), .src(id_src1), .match(mem_hit1));
    sb_match u_mem_src2 (.valid(mem_q.valid), .wb_en(mem_q.wb_en), .dst(mem_q.dst), .src(id_src2), .match(mem_hit2));

    assign ex_any  = ex_hit1  | (id_use_src2 & ex_hit2);
    assign mem_any = mem_hit1 | (id_use_src2 & mem_hit2);

    // With forwarding only a load in EX is too late to forward; without it any
    // producer still in EX or MEM blocks the reader.
    assign hazard = id_valid & (fwd_en ? (ex_any & ex_q.mem_read) : (ex_any | mem_any));

    assign mem_busy   = is_mem_op(mem_q) & ~mem_ready;
    assign freeze_int = mem_busy | (state_q == ST_ERR);

    // Outputs are forced low while reset is held so the pipe sees no stray
    // control from branch_taken before the controller is initialised.
    assign flush  = ~rst & branch_taken;
    assign stall  = ~rst & hazard & ~branch_taken;
    assign freeze = ~rst & freeze_int;
    assign err    = (state_q == ST_ERR);

    assign bubble = stall | flush | ~id_valid;

    assign id_entry = '{valid: 1'b1, wb_en: id_wb_en, mem_read: id_mem_read,
                        mem_write: id_mem_write, dst: id_dst};

    assign sel1_d = pick_sel(fwd_en, ex_hit1, mem_hit1);
    assign sel2_d = id_use_src2 ? pick_sel(fwd_en, ex_hit2, mem_hit2) : FORW_SEL_NONE;

    // Scoreboard shift and forwarding select registers. Everything holds while
    // frozen so the selects stay aligned with the instruction sitting in EX.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_q     <= SB_BUBBLE;
            mem_q    <= SB_BUBBLE;
            sel_src1 <= FORW_SEL_NONE;
            sel_src2 <= FORW_SEL_NONE;
        end else if (!freeze_int) begin
            mem_q <= ex_q;
            if (bubble) begin
                ex_q     <= SB_BUBBLE;
                sel_src1 <= FORW_SEL_NONE;
                sel_src2 <= FORW_SEL_NONE;
            end else begin
                ex_q     <= id_entry;
                sel_src1 <= sel1_d;
                sel_src2 <= sel2_d;
            end
        end
    end

    // Memory sequencing state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_RUN;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // cnt holds the number of wait cycles seen so far; once it reaches the
    // timeout the controller locks up in ERR until reset.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_RUN: begin
                if (mem_busy) begin
                    cnt_d   = CNT_W'(1);
                    state_d = (cnt_d >= CNT_W'(MEM_TIMEOUT)) ? ST_ERR : ST_MEM_WAIT;
                end
            end
            ST_MEM_WAIT: begin
                if (mem_ready) begin
                    state_d = ST_RUN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_d >= CNT_W'(MEM_TIMEOUT))
                        state_d = ST_ERR;
                end
            end
            ST_ERR: begin
                state_d = ST_ERR;
            end
            default: begin
                state_d = ST_RUN;
                cnt_d   = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pipeline_hazard_ctrl
// Directed, table-driven bench for pipeline_hazard_ctrl (MEM_TIMEOUT = 8).
// Inputs change on the falling edge; outputs are sampled 1 ns later.
// -----------------------------------------------------------------------------
module tb_pipeline_hazard_ctrl;
    import hazard_pkg::*;

    localparam int MEM_TIMEOUT = 8;
    localparam int CNT_W       = 5;

    logic       clk, rst;
    logic       fwd_en, id_valid, id_use_src2, id_wb_en, id_mem_read, id_mem_write;
    logic [3:0] id_src1, id_src2, id_dst;
    logic       branch_taken, mem_ready;
    logic       stall, flush, freeze, err;
    logic [1:0] sel_src1, sel_src2;

    int checks = 0;
    int errors = 0;

    pipeline_hazard_ctrl #(.MEM_TIMEOUT(MEM_TIMEOUT), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .fwd_en(fwd_en), .id_valid(id_valid),
        .id_src1(id_src1), .id_src2(id_src2), .id_use_src2(id_use_src2),
        .id_wb_en(id_wb_en), .id_mem_read(id_mem_read), .id_mem_write(id_mem_write),
        .id_dst(id_dst), .branch_taken(branch_taken), .mem_ready(mem_ready),
        .stall(stall), .flush(flush), .freeze(freeze),
        .sel_src1(sel_src1), .sel_src2(sel_src2), .err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string      name;
        logic       fwd;
        logic       vld;
        logic [3:0] s1;
        logic [3:0] s2;
        logic       u2;
        logic       wb;
        logic       mrd;
        logic       mwr;
        logic [3:0] dst;
        logic       br;
        logic       rdy;
        logic       e_stall;
        logic       e_flush;
        logic       e_freeze;
        logic [1:0] e_sel1;
        logic [1:0] e_sel2;
        logic       e_err;
    } vec_t;

    function automatic vec_t mkv(input string name, input logic fwd, input logic vld,
                                 input logic [3:0] s1, input logic [3:0] s2, input logic u2,
                                 input logic wb, input logic mrd, input logic mwr,
                                 input logic [3:0] dst, input logic br, input logic rdy,
                                 input logic e_stall, input logic e_flush, input logic e_freeze,
                                 input logic [1:0] e_sel1, input logic [1:0] e_sel2,
                                 input logic e_err);
        vec_t v;
        v.name = name; v.fwd = fwd; v.vld = vld; v.s1 = s1; v.s2 = s2; v.u2 = u2;
        v.wb = wb; v.mrd = mrd; v.mwr = mwr; v.dst = dst; v.br = br; v.rdy = rdy;
        v.e_stall = e_stall; v.e_flush = e_flush; v.e_freeze = e_freeze;
        v.e_sel1 = e_sel1; v.e_sel2 = e_sel2; v.e_err = e_err;
        return v;
    endfunction

    task automatic applyStimulus(input vec_t v);
        fwd_en       = v.fwd;
        id_valid     = v.vld;
        id_src1      = v.s1;
        id_src2      = v.s2;
        id_use_src2  = v.u2;
        id_wb_en     = v.wb;
        id_mem_read  = v.mrd;
        id_mem_write = v.mwr;
        id_dst       = v.dst;
        branch_taken = v.br;
        mem_ready    = v.rdy;
    endtask

    task automatic checkField(input string tag, input string field,
                              input logic [1:0] actual, input logic [1:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s.%s: got %0d expected %0d", tag, field, actual, expected);
        end
    endtask

    task automatic checkOutput(input vec_t v);
        checkField(v.name, "stall",    {1'b0, stall},  {1'b0, v.e_stall});
        checkField(v.name, "flush",    {1'b0, flush},  {1'b0, v.e_flush});
        checkField(v.name, "freeze",   {1'b0, freeze}, {1'b0, v.e_freeze});
        checkField(v.name, "sel_src1", sel_src1,       v.e_sel1);
        checkField(v.name, "sel_src2", sel_src2,       v.e_sel2);
        checkField(v.name, "err",      {1'b0, err},    {1'b0, v.e_err});
    endtask

    task automatic runVec(input vec_t v);
        @(negedge clk);
        applyStimulus(v);
        #1;
        checkOutput(v);
    endtask

    // Reset pulse over a full clock with busy inputs; every output must stay
    // low. Reset is released with an idle ID so the first edge loads a bubble.
    task automatic doReset(input string tag);
        vec_t busy, idle;
        busy = mkv(tag, 1, 1, 5, 5, 1, 1, 1, 0, 5, 1, 0, 0, 0, 0, 0, 0, 0);
        idle = mkv(tag, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        rst = 1'b1;
        applyStimulus(busy);
        #1;
        checkOutput(busy);
        @(posedge clk);
        #1;
        checkOutput(busy);
        @(negedge clk);
        rst = 1'b0;
        applyStimulus(idle);
        #1;
        checkOutput(idle);
    endtask

    vec_t vecs[$];

    initial begin
        // name               fwd vld s1 s2 u2 wb rd wr dst br rdy | stl fl frz s1 s2 err
        vecs.push_back(mkv("add_d3",           1, 1, 0, 0, 0, 1, 0, 0, 3,  0, 1, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mkv("use_d3_fwd",       1, 1, 3, 0, 0, 1, 0, 0, 4,  0, 1, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mkv("sel1_from_mem",    1, 0, 0, 0, 0, 0, 0, 0, 0,  0, 1, 0, 0, 0, 1, 0, 0));
        vecs.push_back(mkv("ldr_d5",           1, 1, 1, 0, 0, 1, 1, 0, 5,  0, 1, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mkv("load_use_stall",   1, 1, 0, 5, 1, 1, 0, 0, 6,  0, 1, 1, 0, 0, 0, 0, 0));
        vecs.push_back(mkv("load_use_release", 1, 1, 0, 5, 1, 1, 0, 0, 6,  0, 1, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mkv("sel2_from_wb",     1, 0, 0, 0, 0, 0, 0, 0, 0,  0, 1, 0, 0, 0, 0, 2, 0));
        vecs.push_back(mkv("nofwd_d7",         0, 1, 0, 0, 0, 1, 0, 0, 7,  0, 1, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mkv("nofwd_stall1",     0, 1, 7, 0, 0, 1, 0, 0, 8,  0, 1, 1, 0, 0, 0, 0, 0));
        vecs.push_back(mkv("nofwd_stall2",     0, 1, 7, 0, 0, 1, 0, 0, 8,  0, 1, 1, 0, 0, 0, 0, 0));
        vecs.push_back(mkv("nofwd_wb_ok",      0, 1, 7, 0, 0, 1, 0, 0, 8,  0, 1, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mkv("nofwd_sel_none",   0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 1, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mkv("ldr_d9",           1, 1, 0, 0, 0, 1, 1, 0, 9,  0, 1, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mkv("branch_loaduse",   1, 1, 9, 0, 0, 1, 0, 0, 10, 1, 1, 0, 1, 0, 0, 0, 0));
        vecs.push_back(mkv("flush_sel_none",   1, 0, 0, 0, 0, 0, 0, 0, 0,  0, 1, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mkv("ldr_d11",          1, 1, 0, 0, 0, 1, 1, 0, 11, 0, 1, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mkv("src2_unused",      1, 1, 0, 11, 0, 1, 0, 0, 12, 0, 1, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mkv("sel2_gated",       1, 0, 0, 0, 0, 0, 0, 0, 0,  0, 1, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mkv("str_issue",        1, 1, 0, 0, 0, 0, 0, 1, 0,  0, 1, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mkv("str_to_mem",       1, 0, 0, 0, 0, 0, 0, 0, 0,  0, 1, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mkv("str_wait",         1, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 1, 0, 0, 0));
        vecs.push_back(mkv("str_done",         1, 0, 0, 0, 0, 0, 0, 0, 0,  0, 1, 0, 0, 0, 0, 0, 0));

        rst = 1'b1;
        applyStimulus(mkv("init", 1, 1, 5, 5, 1, 1, 1, 0, 5, 1, 0, 0, 0, 0, 0, 0, 0));
        $display("[TB] reset and directed vector table");
        doReset("reset_state");

        foreach (vecs[i])
            runVec(vecs[i]);

        // Load in MEM waits three cycles with a branch arriving mid-freeze;
        // the dependent ADD must still see the load once the pipe resumes.
        $display("[TB] memory wait sequence");
        runVec(mkv("wait_ldr",    1, 1, 0, 0, 0, 1, 1, 0, 5, 0, 1, 0, 0, 0, 0, 0, 0));
        runVec(mkv("wait_lu",     1, 1, 5, 0, 0, 1, 0, 0, 6, 0, 1, 1, 0, 0, 0, 0, 0));
        runVec(mkv("wait_1",      1, 1, 5, 0, 0, 1, 0, 0, 6, 0, 0, 0, 0, 1, 0, 0, 0));
        runVec(mkv("wait_2_br",   1, 1, 5, 0, 0, 1, 0, 0, 6, 1, 0, 0, 1, 1, 0, 0, 0));
        runVec(mkv("wait_3_br",   1, 1, 5, 0, 0, 1, 0, 0, 6, 1, 0, 0, 1, 1, 0, 0, 0));
        runVec(mkv("wait_resume", 1, 1, 5, 0, 0, 1, 0, 0, 6, 0, 1, 0, 0, 0, 0, 0, 0));
        runVec(mkv("wait_fwd_wb", 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 2, 0, 0));

        // Reset in the middle of a memory wait clears the wait count.
        $display("[TB] reset during memory wait");
        runVec(mkv("rstw_ldr",  1, 1, 0, 0, 0, 1, 1, 0, 5, 0, 1, 0, 0, 0, 0, 0, 0));
        runVec(mkv("rstw_mem",  1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0));
        for (int k = 0; k < 3; k++)
            runVec(mkv("rstw_wait", 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0));
        doReset("rstw_reset");
        for (int k = 0; k < 10; k++)
            runVec(mkv("rstw_after", 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));

        // mem_ready never arrives: err must appear after the timeout and stick.
        $display("[TB] memory timeout sequence");
        runVec(mkv("to_ldr", 1, 1, 0, 0, 0, 1, 1, 0, 5, 0, 1, 0, 0, 0, 0, 0, 0));
        runVec(mkv("to_mem", 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0));
        for (int w = 1; w <= 12; w++) begin
            @(negedge clk);
            applyStimulus(mkv("to_wait", 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, (w == 12), 0, 0, 1, 0, 0, 0));
            #1;
            checkField("to_wait", "freeze", {1'b0, freeze}, 2'd1);
            if (w <= 7)
                checkField("to_wait_early", "err", {1'b0, err}, 2'd0);
            if (w >= 9)
                checkField("to_wait_late", "err", {1'b0, err}, 2'd1);
        end

        // Reset is the only way out of the error state.
        doReset("err_reset");
        runVec(mkv("err_cleared", 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
